alu_seq: RTL and testbench

Multi-cycle operation sequencer that drives the shared 8-bit add/sub ALU to perform unsigned add, subtract, 8x8 multiply and 8/8 divide. It owns the ALU operand and `sub` inputs while busy. It performs one ALU evaluation per clock and registers the intermediate state. It sits between the CPU control unit, which issues `start`/`op`, and the ALU.

---
 rtl/alu_seq.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle add/sub/mul/div sequencer that borrows the shared 8-bit add/sub ALU.
// Latency: ADD/SUB/DIV-by-0 = 2 cycles start->done; MUL/DIV = 9 cycles start->done.
// Backpressure: start is ignored while busy; a start seen in the done cycle is accepted with no bubble.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  opa,
  input  logic [7:0]  opb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_sub,
  input  logic [7:0]  alu_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [7:0]  a_q;      // A / multiplicand M
  logic [7:0]  b_q;      // B / divisor D
  logic [7:0]  hi_q;     // P_hi for MUL, remainder R for DIV
  logic [7:0]  lo_q;     // P_lo for MUL, quotient Q for DIV
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] result_q;

  logic [7:0]  hi_d;
  logic [7:0]  lo_d;
  logic [15:0] result_d;
  logic        err_d;
  logic        fin;
  logic        c_add;
  logic        c_sub;
  logic        div_ok;
  logic        last_iter;

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

  assign last_iter = (cnt_q == 3'd7);

  // ALU drive: operands come straight from state registers; parked at zero outside RUN
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_sub = 1'b0;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_ADD: begin
          alu_a = a_q;
          alu_b = b_q;
        end
        OP_SUB: begin
          alu_a   = a_q;
          alu_b   = b_q;
          alu_sub = 1'b1;
        end
        OP_MUL: begin
          alu_a = hi_q;
          alu_b = lo_q[0] ? a_q : 8'h00;
        end
        default: begin
          // divide by zero never touches the ALU
          if (b_q != 8'h00) begin
            alu_a   = {hi_q[6:0], lo_q[7]};
            alu_b   = b_q;
            alu_sub = 1'b1;
          end
        end
      endcase
    end
  end

  // Carry/no-borrow reconstructed from ALU operands and sum since ALU flags are unused
  always_comb begin
    c_add = (alu_a[7] & alu_b[7]) | ((alu_a[7] | alu_b[7]) & ~alu_out[7]);
    c_sub = (alu_a[7] & ~alu_b[7]) | ((alu_a[7] | ~alu_b[7]) & ~alu_out[7]);
  end

  // Iteration datapath and completion decode for the current RUN cycle
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    err_d    = 1'b0;
    fin      = 1'b0;
    // R[7] set means the shifted-out bit makes the trial remainder exceed any 8-bit divisor
    div_ok   = c_sub | hi_q[7];
    if (state_q == S_RUN) begin
      case (op_q)
        OP_ADD: begin
          fin      = 1'b1;
          result_d = {7'b0, c_add, alu_out};
        end
        OP_SUB: begin
          fin      = 1'b1;
          result_d = {7'b0, ~c_sub, alu_out};
        end
        OP_MUL: begin
          hi_d = {c_add, alu_out[7:1]};
          lo_d = {alu_out[0], lo_q[7:1]};
          if (last_iter) begin
            fin      = 1'b1;
            result_d = {hi_d, lo_d};
          end
        end
        default: begin
          if (b_q == 8'h00) begin
            fin      = 1'b1;
            err_d    = 1'b1;
            result_d = 16'hFFFF;
          end else begin
            hi_d = div_ok ? alu_out : alu_a;
            lo_d = {lo_q[6:0], div_ok};
            if (last_iter) begin
              fin      = 1'b1;
              result_d = {hi_d, lo_d};
            end
          end
        end
      endcase
    end
  end

  // Control FSM with registered status outputs; accepting from DONE avoids an idle bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 3'd1;
          if (fin) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= err_d;
            result_q <= result_d;
          end
        end
        default: begin
          // S_IDLE and S_DONE both accept a new request
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            op_q    <= op;
            a_q     <= opa;
            b_q     <= opb;
            hi_q    <= 8'h00;
            lo_q    <= (op == OP_MUL) ? opb : opa;
            cnt_q   <= 3'd0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_sub;
  logic [7:0]  alu_out;

  int total;
  int bad;

  // expected {err, result}, pushed at issue, popped at done
  logic [16:0] exp_q[$];

  alu_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sub (alu_sub),
    .alu_out (alu_out)
  );

  // shared 8-bit add/sub ALU
  assign alu_out = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s9;
    logic [15:0] r;
    logic [16:0] res;
    case (o)
      2'd0: begin
        s9  = {1'b0, a} + {1'b0, b};
        res = {1'b0, 7'b0, s9};
      end
      2'd1: begin
        s9  = {1'b0, a} - {1'b0, b};
        res = {1'b0, 7'b0, s9};
      end
      2'd2: begin
        r   = 16'(a) * 16'(b);
        res = {1'b0, r};
      end
      default: begin
        if (b == 8'h00) res = {1'b1, 16'hFFFF};
        else            res = {1'b0, a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_done: result=%h err=%b with nothing outstanding", result, err);
      end
      if (exp_q.size() != 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        total++;
        assert (result === e[15:0]) else begin
          bad++;
          $error("FAIL result: got %h want %h", result, e[15:0]);
        end
        total++;
        assert (err === e[16]) else begin
          bad++;
          $error("FAIL err: got %b want %b", err, e[16]);
        end
        total++;
        assert (busy === 1'b0) else begin
          bad++;
          $error("FAIL busy_at_done: got %b want 0", busy);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // issue one op at a negedge; returns at the negedge where done is seen
  task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input int exp_lat, input int glitch_at);
    int n;
    bit got;
    exp_q.push_back(model(o, a, b));
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    n     = 0;
    got   = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (done) got = 1'b1;
      else if (glitch_at > 0 && n == glitch_at) begin
        start = 1'b1;
        op    = 2'd0;
        opa   = 8'($urandom);
        opb   = 8'($urandom);
      end
      if (n == 1) chk("busy_after_accept", 32'(busy), 32'(!got));
    end
    chk("latency", 32'(n), 32'(exp_lat));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    opa   = 8'h00;
    opb   = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_alu", {23'd0, alu_sub, alu_a}, 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'd0, 8'hFF, 8'h01, 2, 0);   // ADD -> 0x0100
    @(negedge clk);
    chk("idle_alu", {15'd0, alu_sub, alu_a, alu_b}, 32'd0);
    do_op(2'd1, 8'h05, 8'h07, 2, 0);   // SUB -> 0x01FE
    do_op(2'd2, 8'd200, 8'd150, 9, 0); // MUL -> 0x7530, back-to-back
    do_op(2'd2, 8'd255, 8'd255, 9, 0); // 0xFE01
    do_op(2'd2, 8'd0, 8'd77, 9, 0);    // 0x0000
    @(negedge clk);
    do_op(2'd3, 8'd200, 8'd7, 9, 0);   // 0x041C
    do_op(2'd3, 8'd255, 8'd200, 9, 0); // 0x3701
    do_op(2'd3, 8'd255, 8'd255, 9, 0); // 0x0001
    do_op(2'd3, 8'd77, 8'd0, 2, 0);    // err, 0xFFFF
    chk("err_held", 32'(err), 32'd1);
    do_op(2'd0, 8'd3, 8'd4, 2, 0);     // clears err
    @(negedge clk);
    do_op(2'd2, 8'd200, 8'd150, 9, 3); // start pulse mid-MUL ignored
    do_op(2'd2, 8'd17, 8'd19, 9, 0);   // issued in done cycle

    // reset mid-DIV
    @(negedge clk);
    op    = 2'd3;
    opa   = 8'd200;
    opb   = 8'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_alu", {15'd0, alu_sub, alu_a, alu_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    do_op(2'd2, 8'd13, 8'd11, 9, 0);

    // randomized tail
    for (int i = 0; i < 10; i++) begin
      logic [1:0] ro;
      logic [7:0] ra;
      logic [7:0] rb;
      int lat;
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = (i == 5) ? 8'd0 : 8'($urandom);
      if (ro == 2'd3 && rb == 8'd0) lat = 2;
      else if (ro[1]) lat = 9;
      else lat = 2;
      do_op(ro, ra, rb, lat, 0);
      if (i[0]) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
